response_uart_tx: RTL and testbench
===================================

Name: response_uart_tx

Overview:
- Downstream stage of the sensor decoder facade.
- Captures each completed response pair (response_code, response) when the decoder's `finished` rises.
- Serialises the pair as two UART 8N1 bytes (code first, then value) on the board TX pin to the host client.
- Holds one pending pair while a frame is in flight, so back-to-back completions are not lost.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum legal value 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- finished  input  1  decoder completion level; a 0->1 transition marks a new valid pair.
- response_code  input  8  decoder response code; sampled on the capture cycle.
- response  input  8  decoder response value; sampled on the capture cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is being transmitted.
- pending  output  1  high while the one-entry holding buffer is occupied.
- overflow  output  1  sticky; set when a pair is dropped.

Behaviour:
- Interface: one clock, `clock`; reset is `reset`, synchronous, active-high. Everything is in this single domain.
- Reset values: tx=1, busy=0, pending=0, overflow=0; state IDLE; finished_q=0; bit/baud counters=0.
- Capture event: finished=1 && finished_q=0, where finished_q is finished registered. Re-assertion only after finished returns low. A level held high produces exactly one capture.
- On a capture in IDLE (busy=0):
  - latch {response_code, response} into the frame register.
  - busy=1 and tx=0 (start bit of byte0) from the next cycle.
- State machine, per byte:
  - IDLE -> START -> DATA -> STOP.
  - Then either START for byte1, or frame end after byte1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - byte1 START follows byte0 STOP immediately; there is no inter-byte gap.
- Frame length: exactly 20*CLKS_PER_BIT cycles of busy=1. Latency is 1 cycle from capture to the first start-bit cycle.
- Frame end, on the last cycle of byte1 STOP:
  - if pending=1: the next cycle loads the pending pair into the frame register, clears pending, busy stays 1, and tx=0 begins the new start bit. No idle gap.
  - else: the next cycle goes to IDLE with busy=0 and tx=1.
- Capture while busy=1 and pending=0: store the pair in the holding buffer and set pending=1. The frame in flight is unaffected.
- Capture while busy=1 and pending=1: drop the new pair, set overflow=1, and keep the held pair unchanged. overflow clears only on reset.
- Capture on the same cycle as frame end:
  - treated as busy; the pair goes to the holding buffer, which is guaranteed empty or just being drained.
  - if the buffer was draining that cycle, the drained pair transmits first and the new pair stays pending.
- Inputs are sampled only on capture cycles. Changes to response or response_code mid-frame do not affect tx.
- Reset mid-frame: the next cycle has tx=1, busy=0, pending=0, and the frame is abandoned. A finished already high at reset release is captured once, since finished_q=0 after reset.
- Counter widths: the baud counter must be wide enough to hold CLKS_PER_BIT-1; the bit index is 3 bits; the byte select is 1 bit.

Test Plan:
- Use CLKS_PER_BIT=4 for all scenarios.
- Single pair: pulse finished with code=0x11, value=0x19. tx must be:
  - 0 (start), then 1,0,0,0,1,0,0,0, then 1 (stop);
  - 0 (start), then 1,0,0,1,1,0,0,0, then 1 (stop);
  - each bit 4 cycles, busy high for exactly 80 cycles starting the cycle after capture.
- Held level: finished high for 200 cycles with code=0x10, value=0xDF. Exactly one 80-cycle frame; pending stays 0.
- Back-to-back: capture 0x12/0x37, then at cycle 30 capture 0x11/0x1A.
  - pending=1 from cycle 31.
  - the second frame starts the cycle after the first ends; total busy 160 cycles, with no idle cycle between frames.
- Overflow: three captures within the first frame (0x11/0x01, 0x11/0x02, 0x11/0x03).
  - frames 0x01 and 0x02 are sent.
  - 0x03 is dropped and overflow=1 persists until reset.
- Reset mid-frame: assert reset at cycle 25 of a frame. Next cycle tx=1, busy=0, pending=0, overflow=0; a subsequent capture sends a full correct frame.
- Input stability: change response to 0xFF at cycle 10 of a 0x12/0x2A frame. The transmitted second byte is still 0x2A.

Source files
------------

// File: rtl/response_uart_tx.sv
// UART 8N1 transmitter for decoder response pairs: sends {code, value} as two bytes
// and buffers one extra pair while a frame is in flight.
module response_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       finished,
    input  logic [7:0] response_code,
    input  logic [7:0] response,
    output logic       tx,
    output logic       busy,
    output logic       pending,
    output logic       overflow
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic             r_byte;
    logic [15:0]      r_frame;
    logic [15:0]      r_hold;
    logic             r_pending;
    logic             r_overflow;
    logic             r_finished_q;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]       w_bit_nxt;
    logic             w_byte_nxt;
    logic [15:0]      w_frame_nxt;
    logic [15:0]      w_hold_nxt;
    logic             w_pending_nxt;
    logic             w_overflow_nxt;

    logic             w_capture;
    logic             w_baud_done;
    logic             w_frame_end;
    logic [7:0]       w_cur_byte;
    logic [15:0]      w_pair;

    assign w_capture   = finished & ~r_finished_q;
    assign w_baud_done = (r_baud == BAUD_MAX);
    assign w_frame_end = (r_state == StStop) && w_baud_done && r_byte;
    assign w_cur_byte  = r_byte ? r_frame[7:0] : r_frame[15:8];
    assign w_pair      = {response_code, response};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_baud       <= '0;
            r_bit        <= '0;
            r_byte       <= 1'b0;
            r_frame      <= '0;
            r_hold       <= '0;
            r_pending    <= 1'b0;
            r_overflow   <= 1'b0;
            r_finished_q <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_byte       <= w_byte_nxt;
            r_frame      <= w_frame_nxt;
            r_hold       <= w_hold_nxt;
            r_pending    <= w_pending_nxt;
            r_overflow   <= w_overflow_nxt;
            r_finished_q <= finished;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_bit_nxt      = r_bit;
        w_byte_nxt     = r_byte;
        w_frame_nxt    = r_frame;
        w_hold_nxt     = r_hold;
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;

        unique case (r_state)
            StIdle: begin
                if (w_capture) begin
                    w_frame_nxt = w_pair;
                    w_state_nxt = StStart;
                    w_baud_nxt  = '0;
                    w_byte_nxt  = 1'b0;
                end
            end
            StStart: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = StData;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            StData: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = StStop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            StStop: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (!r_byte) begin
                        w_byte_nxt  = 1'b1;
                        w_state_nxt = StStart;
                    end else if (r_pending) begin
                        // Chain the held pair straight into a new start bit.
                        w_frame_nxt   = r_hold;
                        w_pending_nxt = 1'b0;
                        w_byte_nxt    = 1'b0;
                        w_state_nxt   = StStart;
                    end else begin
                        w_byte_nxt  = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // A capture coinciding with a drain refills the buffer the drain just emptied.
        if (w_capture && (r_state != StIdle)) begin
            if (!r_pending || w_frame_end) begin
                w_hold_nxt    = w_pair;
                w_pending_nxt = 1'b1;
            end else begin
                w_overflow_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (r_state)
            StIdle:  tx = 1'b1;
            StStart: tx = 1'b0;
            StData:  tx = w_cur_byte[r_bit];
            StStop:  tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

    assign busy     = (r_state != StIdle);
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_response_uart_tx.sv
// Self-checking bench for response_uart_tx: directed plan scenarios plus random
// stimulus, all compared every cycle against a frame-timeline reference model.
module tb_response_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 20 * CPB;

    logic       clock;
    logic       reset;
    logic       finished;
    logic [7:0] response_code;
    logic [7:0] response;
    logic       tx;
    logic       busy;
    logic       pending;
    logic       overflow;

    int n_cmp;
    int n_err;
    int busy_cnt;

    // Reference model: a frame is a timeline t = 0 .. FRAME_LEN-1 over a 16-bit pair.
    logic        m_busy;
    int          m_t;
    logic [15:0] m_frame;
    logic [15:0] m_q[$];
    logic        m_ovf;
    logic        m_finq;

    response_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .finished     (finished),
        .response_code(response_code),
        .response     (response),
        .tx           (tx),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic model_tx();
        int         bitn;
        int         pos;
        logic [7:0] byt;
        if (!m_busy) return 1'b1;
        bitn = m_t / CPB;
        pos  = bitn % 10;
        byt  = (bitn / 10 == 0) ? m_frame[15:8] : m_frame[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    task automatic model_next(input logic rst, input logic fin, input logic [7:0] c,
                              input logic [7:0] v);
        logic cap;
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_q.delete();
            m_ovf  = 1'b0;
            m_finq = 1'b0;
            return;
        end
        cap = fin && !m_finq;
        if (m_busy) begin
            if (m_t == FRAME_LEN - 1) begin
                if (m_q.size() > 0) begin
                    m_frame = m_q.pop_front();
                    m_t     = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_t++;
            end
            if (cap) begin
                if (m_q.size() == 0) m_q.push_back({c, v});
                else m_ovf = 1'b1;
            end
        end else if (cap) begin
            m_busy  = 1'b1;
            m_t     = 0;
            m_frame = {c, v};
        end
        m_finq = fin;
    endtask

    // Drive one cycle of inputs, advance the model, then compare at the falling edge.
    task automatic step(input logic rst, input logic fin, input logic [7:0] c,
                        input logic [7:0] v);
        reset         = rst;
        finished      = fin;
        response_code = c;
        response      = v;
        model_next(rst, fin, c, v);
        @(negedge clock);
        check_eq("tx", 16'(tx), 16'(model_tx()));
        check_eq("busy", 16'(busy), 16'(m_busy));
        check_eq("pending", 16'(pending), 16'(m_q.size() > 0));
        check_eq("overflow", 16'(overflow), 16'(m_ovf));
        if (busy) busy_cnt++;
    endtask

    initial begin
        logic       rfin;
        logic       rrst;
        logic [7:0] rc;
        logic [7:0] rv;

        n_cmp    = 0;
        n_err    = 0;
        busy_cnt = 0;
        m_busy   = 1'b0;
        m_t      = 0;
        m_frame  = '0;
        m_ovf    = 1'b0;
        m_finq   = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 8'h00);

        // Single pair 0x11/0x19.
        busy_cnt = 0;
        step(1'b0, 1'b1, 8'h11, 8'h19);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        check_eq("single_busy_len", 16'(busy_cnt), 16'(FRAME_LEN));

        // Held level: one frame only.
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 8'h10, 8'hDF);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        check_eq("held_busy_len", 16'(busy_cnt), 16'(FRAME_LEN));

        // Back-to-back: second capture at cycle 30 of the first frame.
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0) step(1'b0, 1'b1, 8'h12, 8'h37);
            else if (i == 30) step(1'b0, 1'b1, 8'h11, 8'h1A);
            else step(1'b0, 1'b0, 8'h00, 8'h00);
        end
        check_eq("b2b_busy_len", 16'(busy_cnt), 16'(2 * FRAME_LEN));

        // Overflow: three captures inside the first frame.
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 0 || i == 10 || i == 20) step(1'b0, 1'b1, 8'h11, 8'(i / 10 + 1));
            else step(1'b0, 1'b0, 8'h00, 8'h00);
        end
        check_eq("ovf_busy_len", 16'(busy_cnt), 16'(2 * FRAME_LEN));
        check_eq("ovf_sticky", 16'(overflow), 16'd1);

        // Reset at cycle 25 of a frame, then a clean frame.
        step(1'b0, 1'b1, 8'h5A, 8'hC3);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        check_eq("rst_tx", 16'(tx), 16'd1);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_ovf", 16'(overflow), 16'd0);
        busy_cnt = 0;
        step(1'b0, 1'b1, 8'hA5, 8'h3C);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        check_eq("post_rst_busy_len", 16'(busy_cnt), 16'(FRAME_LEN));

        // Input stability: response changes mid-frame.
        step(1'b0, 1'b1, 8'h12, 8'h2A);
        for (int i = 1; i < 100; i++) begin
            step(1'b0, 1'b0, 8'h12, (i >= 10) ? 8'hFF : 8'h2A);
        end

        // Randomised traffic with occasional resets.
        rfin = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) rfin = ~rfin;
            rrst = ($urandom_range(0, 1499) == 0);
            rc   = 8'($urandom);
            rv   = 8'($urandom);
            step(rrst, rfin, rc, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
